// File: rtl/keymem_arb_pkg.sv
// Shared types and widths for the keymem lookup arbiter.
package keymem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int KEY_WIDTH    = 256;
    localparam int KEY_ID_WIDTH = 32;
    localparam int MAX_REQ      = 8;
    // Index width sized for the largest supported requester count.
    localparam int IDX_W        = $clog2(MAX_REQ);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after rr_ptr,
// wrapping modulo NUM_REQ.
module rr_arbiter
    import keymem_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] winner_oh,
    output logic [IDX_W-1:0]   winner_idx,
    output logic               any_req
);

    int   idx;
    logic found;

    // Scan NUM_REQ positions starting at rr_ptr; the first hit wins.
    always_comb begin
        idx        = 0;
        found      = 1'b0;
        winner_idx = '0;
        any_req    = |req;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                winner_idx = IDX_W'(idx);
            end
        end
    end

    // One-hot form of the winning index, empty when nobody requests.
    always_comb begin
        winner_oh = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            winner_oh[j] = any_req && (winner_idx == IDX_W'(j));
        end
    end

endmodule

// File: rtl/keymem_arbiter.sv
// Round-robin arbiter sharing one keymem lookup port between NUM_REQ
// network paths. Optional response timeout: KEYMEM_ARB_TIMEOUT_EN.
module keymem_arbiter
    import keymem_arb_pkg::*;
#(
    parameter int          NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                            key_clk,
    input  logic                            key_aresetn,
    input  logic [NUM_REQ-1:0]              req_key_req,
    input  logic [NUM_REQ*KEY_ID_WIDTH-1:0] req_key_id,
    output logic [NUM_REQ-1:0]              req_key_ack,
    output logic [NUM_REQ-1:0]              req_key_err,
    output logic [KEY_WIDTH-1:0]            req_key,
    output logic                            key_req,
    output logic [KEY_ID_WIDTH-1:0]         key_id,
    input  logic                            key_ack,
    input  logic [KEY_WIDTH-1:0]            key
);

    state_t                  state, state_nxt;
    logic [IDX_W-1:0]        rr_ptr, grant, win_idx;
    logic [NUM_REQ-1:0]      grant_oh, win_oh, req_masked;
    logic                    any_req, last_resp, timeout;
    logic [KEY_ID_WIDTH-1:0] sel_id;

    // The requester just served may still hold its request for one cycle;
    // hide it in the IDLE cycle right after its RESP.
    always_comb begin
        grant_oh = '0;
        for (int i = 0; i < NUM_REQ; i++) grant_oh[i] = (grant == IDX_W'(i));
        req_masked = req_key_req & ~(last_resp ? grant_oh : '0);
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req        (req_masked),
        .rr_ptr     (rr_ptr),
        .winner_oh  (win_oh),
        .winner_idx (win_idx),
        .any_req    (any_req)
    );

    // Mux the winner's key id for latching.
    always_comb begin
        sel_id = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (win_oh[i]) sel_id = req_key_id[i*KEY_ID_WIDTH +: KEY_ID_WIDTH];
    end

`ifdef KEYMEM_ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    logic        err_flag;

    assign timeout     = (state == REQ) && (tmo_cnt == 16'(TIMEOUT_CYCLES));
    assign req_key_err = (state == RESP) ? (grant_oh & {NUM_REQ{err_flag}}) : '0;

    // Count REQ cycles; remember whether the lookup ended by timeout.
    always_ff @(posedge key_clk or negedge key_aresetn) begin
        if (!key_aresetn) begin
            tmo_cnt  <= '0;
            err_flag <= 1'b0;
        end else begin
            if (state == REQ) tmo_cnt <= tmo_cnt + 16'd1;
            else              tmo_cnt <= '0;
            if (state == REQ && (key_ack || timeout)) err_flag <= !key_ack;
        end
    end
`else
    assign timeout     = 1'b0;
    assign req_key_err = '0;
`endif

    assign key_req     = (state == REQ);
    assign req_key_ack = (state == RESP) ? grant_oh : '0;

    // Next-state logic; a key_ack outside REQ is ignored.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = REQ;
            REQ:     if (key_ack || timeout) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge key_clk or negedge key_aresetn) begin
        if (!key_aresetn) state <= IDLE;
        else              state <= state_nxt;
    end

    // Grant, key id, returned key and round-robin pointer.
    always_ff @(posedge key_clk or negedge key_aresetn) begin
        if (!key_aresetn) begin
            rr_ptr    <= '0;
            grant     <= '0;
            key_id    <= '0;
            req_key   <= '0;
            last_resp <= 1'b0;
        end else begin
            last_resp <= (state == RESP);
            case (state)
                IDLE: if (any_req) begin
                    grant  <= win_idx;
                    key_id <= sel_id;
                end
                REQ: begin
                    if (key_ack)      req_key <= key;
                    else if (timeout) req_key <= '0;
                end
                RESP: rr_ptr <= (grant == IDX_W'(NUM_REQ-1)) ? '0 : grant + IDX_W'(1);
                default: ;
            endcase
        end
    end

endmodule
